// File: rtl/rev_pkg.sv
// Shared types for the streaming bit reverser: per-beat reversal modes and the
// occupancy states of the main/skid storage pair.
package rev_pkg;

    typedef enum logic [1:0] {
        REV_BIT = 2'd0,
        REV_GRP = 2'd1,
        REV_IN  = 2'd2,
        PASS    = 2'd3
    } rev_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } rev_state_e;

endpackage

// File: rtl/rev_xform.sv
// Combinational beat transform: full bit reversal, group-order reversal,
// in-group bit reversal or pass-through, selected per beat.
module rev_xform
    import rev_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int GROUP_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  rev_mode_e             mode,
    output logic [DATA_WIDTH-1:0] xdata
);

    localparam int NGRP = DATA_WIDTH / GROUP_WIDTH;

    if ((DATA_WIDTH % GROUP_WIDTH) != 0) begin : g_bad_group
        $error("rev_xform: GROUP_WIDTH (%0d) must divide DATA_WIDTH (%0d)", GROUP_WIDTH, DATA_WIDTH);
    end

    function automatic logic [DATA_WIDTH-1:0] rev_bits(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = d[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rev_groups(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NGRP; k++) begin
            for (int b = 0; b < GROUP_WIDTH; b++) begin
                r[k*GROUP_WIDTH + b] = d[(NGRP-1-k)*GROUP_WIDTH + b];
            end
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rev_in_groups(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NGRP; k++) begin
            for (int b = 0; b < GROUP_WIDTH; b++) begin
                r[k*GROUP_WIDTH + b] = d[k*GROUP_WIDTH + GROUP_WIDTH-1-b];
            end
        end
        return r;
    endfunction

    always_comb begin
        xdata = data;
        case (mode)
            REV_BIT: xdata = rev_bits(data);
            REV_GRP: xdata = rev_groups(data);
            REV_IN:  xdata = rev_in_groups(data);
            default: xdata = data;
        endcase
    end

endmodule

// File: rtl/reverse_stream.sv
// Valid/ready bit reverser: transforms each beat on entry, holds it in a main
// register with a one-entry skid behind it. Optional counter: REV_STATS_EN.
module reverse_stream
    import rev_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int GROUP_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_mode,
`ifdef REV_STATS_EN
    output logic [CNT_WIDTH-1:0]  beat_count,
    input  logic                  stats_clr,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_mode
);

    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("reverse_stream: CNT_WIDTH must be at least 1");
    end

    rev_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] xdata_p0;
    logic [DATA_WIDTH-1:0] main_data_p1, skid_data_p1;
    logic [1:0]            main_mode_p1, skid_mode_p1;
    logic                  fire_in, fire_out;
    logic                  load_main, main_from_skid, load_skid;

    rev_xform #(
        .DATA_WIDTH  (DATA_WIDTH),
        .GROUP_WIDTH (GROUP_WIDTH)
    ) u_xform (
        .data  (in_data),
        .mode  (rev_mode_e'(in_mode)),
        .xdata (xdata_p0)
    );

    // Readiness depends on occupancy only, so no combinational path from out_ready.
    assign in_ready  = (state_q != FULL) && resetn;
    assign out_valid = (state_q != EMPTY);
    assign fire_in   = in_valid && in_ready;
    assign fire_out  = out_valid && out_ready;
    assign out_data  = main_data_p1;
    assign out_mode  = main_mode_p1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (fire_in) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (fire_in && fire_out) begin
                    load_main = 1'b1;
                end else if (fire_in) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (fire_out) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (fire_out) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // ---- stage p0 -> p1: main and skid storage, written only on a transfer ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_data_p1 <= '0;
            main_mode_p1 <= '0;
        end else if (load_main) begin
            main_data_p1 <= main_from_skid ? skid_data_p1 : xdata_p0;
            main_mode_p1 <= main_from_skid ? skid_mode_p1 : in_mode;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_data_p1 <= '0;
            skid_mode_p1 <= '0;
        end else if (load_skid) begin
            skid_data_p1 <= xdata_p0;
            skid_mode_p1 <= in_mode;
        end
    end

`ifdef REV_STATS_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [CNT_WIDTH-1:0] cnt_q;

    // Clear takes priority over an emit in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (stats_clr) begin
            cnt_q <= '0;
        end else if (fire_out) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign beat_count = cnt_q;
`endif

endmodule

// File: tb/tb_reverse_stream.sv
// Directed/table bench for reverse_stream (32-bit beats, 8-bit groups);
// the counter checks are compiled in when REV_STATS_EN is defined.
module tb_reverse_stream;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
`ifdef REV_STATS_EN
    logic [3:0]  beat_count;
    logic        stats_clr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reverse_stream #(
        .DATA_WIDTH  (32),
        .GROUP_WIDTH (8),
        .CNT_WIDTH   (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
`ifdef REV_STATS_EN
        .beat_count (beat_count),
        .stats_clr  (stats_clr),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_mode   (out_mode)
    );

    // Reference transform built from streaming operators.
    function automatic logic [31:0] xf(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] b;
        logic [31:0] g;
        logic [31:0] bg;
        b  = {<<{d}};
        g  = {<<8{d}};
        bg = {<<8{b}};
        case (m)
            2'd0:    return b;
            2'd1:    return g;
            2'd2:    return bg;
            default: return d;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[8];

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Random stream with scoreboard; pv/pr are percent probabilities of in_valid/out_ready.
    task automatic run_stream(input string tag, input int nbeats, input int pv, input int pr);
        logic [31:0] expq[$];
        logic [1:0]  modeq[$];
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        int          bad = 0;
        bit          stall = 1'b0;
        bit          rdy_drop = 1'b0;
        logic [31:0] sd = '0;
        logic [1:0]  sm = '0;
        logic [31:0] ed;
        logic [1:0]  em;
        while (got < nbeats && cyc < 20 * nbeats + 100) begin
            in_valid  = (sent < nbeats) && ($urandom_range(99) < pv);
            in_data   = $urandom;
            in_mode   = 2'($urandom_range(3));
            out_ready = ($urandom_range(99) < pr);
            #1;
            if (stall) begin
                if (!out_valid || out_data !== sd || out_mode !== sm) bad++;
                chk({tag, " stall-stable"}, {31'd0, out_valid, out_data, 30'd0, out_mode}, {31'd0, 1'b1, sd, 30'd0, sm});
            end
            if (pv == 100 && pr == 100 && sent < nbeats && !in_ready) rdy_drop = 1'b1;
            if (in_valid && in_ready) begin
                expq.push_back(xf(in_data, in_mode));
                modeq.push_back(in_mode);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk({tag, " spurious-beat"}, 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ed = expq.pop_front();
                    em = modeq.pop_front();
                    chk({tag, " data"}, 64'(out_data), 64'(ed));
                    chk({tag, " mode"}, 64'(out_mode), 64'(em));
                end
                got++;
            end
            stall = out_valid && !out_ready;
            sd    = out_data;
            sm    = out_mode;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, " beats-emitted"}, 64'(got), 64'(nbeats));
        chk({tag, " leftover"}, 64'(expq.size()), 64'd0);
        if (pv == 100 && pr == 100) chk({tag, " in_ready-held"}, 64'(rdy_drop), 64'd0);
    endtask

    initial begin
        vecs[0] = '{2'd0, 32'h0000_0001, 32'h8000_0000};
        vecs[1] = '{2'd1, 32'h1122_3344, 32'h4433_2211};
        vecs[2] = '{2'd2, 32'h0102_0304, 32'h8040_C020};
        vecs[3] = '{2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{2'd0, 32'hFFFF_0000, 32'h0000_FFFF};
        vecs[5] = '{2'd1, 32'h0000_00FF, 32'hFF00_0000};
        vecs[6] = '{2'd2, 32'h8000_0001, 32'h0100_0080};
        vecs[7] = '{2'd3, 32'h0000_0000, 32'h0000_0000};

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        out_ready = 1'b1;
`ifdef REV_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset out_mode", 64'(out_mode), 64'd0);
`ifdef REV_STATS_EN
        chk("reset beat_count", 64'(beat_count), 64'd0);
`endif
        resetn = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 64'(in_ready), 64'd1);

        // Single beats from the table, each visible one cycle after accept.
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            in_mode  = vecs[i].mode;
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 32'hA5A5_5A5A;
            chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].dout));
            chk($sformatf("vec%0d out_mode", i), 64'(out_mode), 64'(vecs[i].mode));
            @(negedge clk);
            chk($sformatf("vec%0d drained", i), 64'(out_valid), 64'd0);
        end

        run_stream("b2b", 100, 100, 100);
        drain();

        // Stall: A and B fill main+skid, C is refused until the output moves.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001; in_mode = 2'd0;
        chk("stall A in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_data   = 32'h1122_3344; in_mode = 2'd1;
        chk("stall B in_ready", 64'(in_ready), 64'd1);
        chk("stall A out", 64'(out_data), 64'h8000_0000);
        @(negedge clk);
        in_data   = 32'hDEAD_BEEF; in_mode = 2'd3;
        chk("stall C refused", 64'(in_ready), 64'd0);
        chk("stall A held1", 64'(out_data), 64'h8000_0000);
        @(negedge clk);
        chk("stall still full", 64'(in_ready), 64'd0);
        chk("stall A held2", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h8000_0000});
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall B out", 64'(out_data), 64'h4433_2211);
        chk("stall B mode", 64'(out_mode), 64'd1);
        chk("stall C accepted", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall C out", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'hDEAD_BEEF});
        @(negedge clk);
        chk("stall drained", 64'(out_valid), 64'd0);

        run_stream("rand", 1000, 50, 50);
        drain();

        // Asynchronous reset while FULL, then first post-reset beat comes out first.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678; in_mode = 2'd3;
        @(negedge clk);
        in_data   = 32'h9ABC_DEF0;
        @(negedge clk);
        in_valid  = 1'b0;
        chk("pre-reset full", 64'(in_ready), 64'd0);
        #2 resetn = 1'b0;
        #1;
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst out_data", 64'(out_data), 64'd0);
        chk("async rst in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post-rst empty", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0000_00F0; in_mode = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post-rst first beat", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h0F00_0000});
        @(negedge clk);
        chk("post-rst no stale", 64'(out_valid), 64'd0);

`ifdef REV_STATS_EN
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("cnt cleared", 64'(beat_count), 64'd0);
        in_valid = 1'b1;
        in_mode  = 2'd3;
        for (int i = 0; i < 20; i++) begin
            in_data = 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("cnt saturated", 64'(beat_count), 64'd15);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        stats_clr = 1'b1;
        chk("cnt emit pending", 64'(out_valid && out_ready), 64'd1);
        @(negedge clk);
        stats_clr = 1'b0;
        chk("cnt clr wins", 64'(beat_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
